// File: rtl/imm_encode.sv
// RISC-V immediate packer: registered encode/check stage feeding an output FIFO.
// Build with IMM_CHECK_EN defined to enable range/alignment checks and err_count.
module imm_encode #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       immsrc,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [1:0]  immsrc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } rsp_t;

  req_t          s1_req;
  logic          s1_valid;
  rsp_t          s1_rsp;
  rsp_t          mem [DEPTH];
  rsp_t          last_q;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, push, pop, accept;

  assign full     = (count == (AW+1)'(DEPTH));
  assign in_ready = !s1_valid || !full;
  assign accept   = in_valid && in_ready;
  assign push     = s1_valid && !full;
  assign pop      = out_ready && (count != '0);

  // Stage 1 holds the raw request; encoding happens on the registered copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_req   <= '{immsrc, opcode, rd, rs1, rs2, funct3, imm};
    end else if (push) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef IMM_CHECK_EN
  logic fits12, fits13, fits21;
  assign fits12 = (&s1_req.imm[31:11]) | ~(|s1_req.imm[31:11]);
  assign fits13 = (&s1_req.imm[31:12]) | ~(|s1_req.imm[31:12]);
  assign fits21 = (&s1_req.imm[31:20]) | ~(|s1_req.imm[31:20]);
`endif

  always_comb begin
    s1_rsp = '0;
    case (s1_req.immsrc)
      2'b00: s1_rsp.instr = {s1_req.imm[11:0], s1_req.rs1, s1_req.funct3, s1_req.rd, s1_req.opcode};
      2'b01: s1_rsp.instr = {s1_req.imm[11:5], s1_req.rs2, s1_req.rs1, s1_req.funct3,
                             s1_req.imm[4:0], s1_req.opcode};
      2'b10: s1_rsp.instr = {s1_req.imm[12], s1_req.imm[10:5], s1_req.rs2, s1_req.rs1,
                             s1_req.funct3, s1_req.imm[4:1], s1_req.imm[11], s1_req.opcode};
      default: begin
        if (s1_req.opcode == OP_JAL)
          s1_rsp.instr = {s1_req.imm[20], s1_req.imm[10:1], s1_req.imm[11], s1_req.imm[19:12],
                          s1_req.rd, s1_req.opcode};
        else
          s1_rsp.instr = {s1_req.imm[31:12], s1_req.rd, s1_req.opcode};
      end
    endcase
`ifdef IMM_CHECK_EN
    case (s1_req.immsrc)
      2'b00, 2'b01: s1_rsp.err = !fits12;
      2'b10:        s1_rsp.err = !fits13 || s1_req.imm[0];
      default:      s1_rsp.err = (s1_req.opcode == OP_JAL) ? (!fits21 || s1_req.imm[0])
                                                           : (s1_req.imm[11:0] != '0);
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= s1_rsp;
  end

  // last_q keeps the most recently popped word visible while the FIFO is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr   <= rptr + 1'b1;
        last_q <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rptr].instr : last_q.instr;
  assign out_err   = out_valid ? mem[rptr].err   : last_q.err;

`ifdef IMM_CHECK_EN
  logic [CNT_W-1:0] err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           err_q <= '0;
    else if (push && s1_rsp.err && !(&err_q)) err_q <= err_q + 1'b1;
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_imm_encode.sv
// Directed bench for imm_encode: literal vectors plus a scoreboard model checked every cycle.
module tb_imm_encode;
`ifdef IMM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [6:0] OP_I = 7'b0010011, OP_S = 7'b0100011, OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111, OP_U = 7'b0110111;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_err;
  logic [1:0]  immsrc = '0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] imm = '0, out_instr;
  logic [7:0]  err_count;

  int total = 0, bad = 0, err_model = 0;

  typedef struct { logic [31:0] instr; logic err; } exp_t;
  exp_t q[$];

  imm_encode #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Field placement by shift/mask and range checks as signed integer comparisons.
  function automatic exp_t model(input logic [1:0] src, input logic [6:0] op, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [31:0] im);
    exp_t r;
    int s;
    logic [31:0] base;
    s = $signed(im);
    base = (32'(s1) << 15) | (32'(f3) << 12);
    case (src)
      2'd0: begin
        r.instr = ((im & 32'hFFF) << 20) | base | (32'(d) << 7) | 32'(op);
        r.err = (s < -2048) || (s > 2047);
      end
      2'd1: begin
        r.instr = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | base | ((im & 32'h1F) << 7) | 32'(op);
        r.err = (s < -2048) || (s > 2047);
      end
      2'd2: begin
        r.instr = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20) | base
                | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'(op);
        r.err = (s < -4096) || (s > 4094) || (im % 2 != 0);
      end
      default: begin
        if (op == OP_J) begin
          r.instr = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20)
                  | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
          r.err = (s < -1048576) || (s > 1048574) || (im % 2 != 0);
        end else begin
          r.instr = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
          r.err = (im % 4096) != 0;
        end
      end
    endcase
    if (!CHK) r.err = 1'b0;
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      err_model = 0;
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        exp_t e;
        e = model(immsrc, opcode, rd, rs1, rs2, funct3, imm);
        q.push_back(e);
        if (e.err && err_model < 255) err_model++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard: unexpected word %h err=%0b, nothing expected", out_instr, out_err);
      end else if (out_instr !== q[0].instr || out_err !== q[0].err) begin
        bad++;
        $display("FAIL scoreboard: got %h err=%0b, want %h err=%0b", out_instr, out_err, q[0].instr, q[0].err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] src, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [31:0] im);
    immsrc = src; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
  endtask

  task automatic send(input logic [1:0] src, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [31:0] im);
    int n;
    @(negedge clk);
    set_in(src, op, d, s1, s2, f3, im);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Send into an idle pipe and pin the word two edges after acceptance.
  task automatic lit(input string name, input logic [1:0] src, input logic [6:0] op, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                     input logic [31:0] im, input logic [31:0] exp_instr, input logic exp_err);
    send(src, op, d, s1, s2, f3, im);
    chk({name, "_lat_n"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_lat_n1"}, 32'(out_valid), 32'd1);
    chk({name, "_instr"}, out_instr, exp_instr);
    chk({name, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  task automatic fill(output int acc);
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      logic rdy;
      @(negedge clk);
      set_in(2'd0, OP_I, 5'(c + 1), 5'd3, 5'd0, 3'd0, 32'(c * 16 + 7));
      in_valid = 1'b1;
      rdy = in_ready;
      @(posedge clk);
      if (rdy) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int acc, pops;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    lit("beq_odd",    2'd2, OP_B, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3,    32'h00000163, CHK);
    lit("addi_4096",  2'd0, OP_I, 5'd0, 5'd0, 5'd0, 3'd0, 32'd4096, 32'h00000013, CHK);
    @(posedge clk);
    #1 chk("err_count_pair", 32'(err_count), CHK ? 32'd2 : 32'd0);
    lit("addi_m1",    2'd0, OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    lit("sw",         2'd1, OP_S, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8,        32'h0020A423, 1'b0);
    lit("jal",        2'd3, OP_J, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800,      32'h001000EF, 1'b0);
    lit("lui",        2'd3, OP_U, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 1'b0);

    // Range edges, with the consumer stalling on some vectors.
    out_ready = 1'b0;
    send(2'd0, OP_I, 5'd7,  5'd9,  5'd0,  3'd1, 32'd2047);
    send(2'd0, OP_I, 5'd7,  5'd9,  5'd0,  3'd1, -32'sd2048);
    out_ready = 1'b1;
    send(2'd0, OP_I, 5'd31, 5'd31, 5'd0,  3'd7, 32'd2048);
    send(2'd1, OP_S, 5'd0,  5'd4,  5'd31, 3'd0, -32'sd2049);
    send(2'd1, OP_S, 5'd0,  5'd4,  5'd31, 3'd2, 32'd2047);
    out_ready = 1'b0;
    send(2'd2, OP_B, 5'd0,  5'd1,  5'd2,  3'd1, 32'd4094);
    send(2'd2, OP_B, 5'd0,  5'd1,  5'd2,  3'd1, -32'sd4096);
    out_ready = 1'b1;
    send(2'd2, OP_B, 5'd0,  5'd1,  5'd2,  3'd4, 32'd4096);
    send(2'd2, OP_B, 5'd0,  5'd1,  5'd2,  3'd5, -32'sd4098);
    send(2'd3, OP_J, 5'd3,  5'd0,  5'd0,  3'd0, 32'd1048574);
    send(2'd3, OP_J, 5'd3,  5'd0,  5'd0,  3'd0, -32'sd1048576);
    send(2'd3, OP_J, 5'd3,  5'd0,  5'd0,  3'd0, 32'd1048576);
    send(2'd3, OP_J, 5'd3,  5'd0,  5'd0,  3'd0, 32'd5);
    send(2'd3, OP_U, 5'd8,  5'd0,  5'd0,  3'd0, 32'hFFFFF000);
    send(2'd3, OP_U, 5'd8,  5'd0,  5'd0,  3'd0, 32'h00001001);
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("err_count_model", 32'(err_count), 32'(err_model));

    // Backpressure: stage 1 plus DEPTH entries.
    out_ready = 1'b0;
    fill(acc);
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid) pops++;
      @(negedge clk);
    end
    chk("bp_drain_rate", 32'(pops), 32'd5);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a drain.
    out_ready = 1'b0;
    fill(acc);
    chk("bp2_accepted", 32'(acc), 32'd5);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_instr", out_instr, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_err_count", 32'(err_count), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("post_rst_no_word", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
- Inverse of the datapath immediate extender: packs a full 32-bit immediate plus register/funct fields into a RISC-V instruction word.
- Immediate format is selected by the same immsrc/opcode scheme the decode side uses.
- Used by the boot loader / test-program generator to build instruction words before they are written into instruction memory.
- Two-stage design: a registered encode/check stage feeding an output FIFO, with valid/ready handshakes on both sides.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, ≥2).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- immsrc  input  2  00 I, 01 S, 10 B, 11 J or U (see Behaviour).
- opcode  input  7  instruction opcode; copied to word[6:0].
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- imm  input  32  full immediate value (byte offset / full U value).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer pop.
- out_instr  output  32  encoded instruction word at FIFO head.
- out_err  output  1  immediate failed range/alignment check for this word.
- err_count  output  CNT_W  saturating count of errored words accepted.

Behaviour:
- **Reset (async, reset_n=0):** FIFO empty, stage-1 empty, out_valid=0, out_instr=0, out_err=0, err_count=0, in_ready=1 the first cycle after release.
- **Encoding**, decided in stage 1 from registered inputs:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - immsrc=11 with opcode=1101111 (J): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - immsrc=11 otherwise (U): {imm[31:12], rd, opcode}.
  - Unused fields (rs2 for I; rd/rs fields overwritten by immediate bits) are ignored.
- **Range/alignment checks** (when enabled):
  - I/S: imm must be in signed 12-bit range −2048..2047.
  - B: −4096..4094 and imm[0]=0.
  - J: −1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - Failure sets out_err for that word. The word is still emitted with the truncated bits above.
- **Stage 1:**
  - One register, s1_valid.
  - Loaded on the accept edge.
  - Transfers to FIFO on any edge where s1_valid && FIFO not full (fullness sampled before that edge's pop).
- **in_ready** = !s1_valid || !fifo_full (combinational from registered state; no dependence on in_valid).
- **Simultaneous accept and transfer:** stage 1 reloads in the same cycle; sustained throughput is 1 word/cycle.
- **Latency:** input accepted at edge N → word at FIFO head, out_valid=1, after edge N+1 (2 cycles, no bypass).
- **Full FIFO with pop:** a pop and a stage-1 push in the same cycle with the FIFO full → pop happens, push blocked until the next edge. No loss, no duplication.
- **Empty FIFO:** out_ready ignored; out_instr/out_err hold their last value.
- **Order:** words leave in acceptance order. Pointers wrap modulo DEPTH. Count is tracked 0..DEPTH.
- **Backpressure capacity:** DEPTH+1 words (FIFO plus stage 1).
- **err_count:** increments on the stage-1 → FIFO transfer of a word with err=1; saturates at all-ones.
- **Reset mid-operation:** all in-flight words discarded immediately. No partial word appears after release.
- **Stability:** out_instr/out_err remain stable while out_valid && !out_ready.

Optional Feature:
- Macro: IMM_CHECK_EN.
- **Defined:** range/alignment checks and err_count are active as above.
- **Undefined:**
  - No check logic is built.
  - out_err is tied to 0 and err_count to 0.
  - Encoding, latency and handshake are identical.

Test Plan:
- ADDI x1,x0,−1: immsrc=00, opcode=0010011, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF → out_instr=0xFFF00093, out_err=0, out_valid two cycles after accept.
- SW x2,8(x1): immsrc=01, opcode=0100011, rs1=1, rs2=2, funct3=010, imm=8 → 0x0020A423.
- JAL x1,+2048: immsrc=11, opcode=1101111, rd=1, imm=0x800 → 0x001000EF.
- LUI x5,0x12345000: immsrc=11, opcode=0110111, rd=5, imm=0x12345000 → 0x123452B7.
- BEQ with imm=3, then ADDI with imm=4096 (IMM_CHECK_EN defined):
  - both words emitted with out_err=1 and err_count=2;
  - same run without the macro: out_err=0 and err_count=0.
- Backpressure, DEPTH=4, out_ready=0, in_valid held high:
  - exactly 5 words accepted, then in_ready=0;
  - raise out_ready → 5 words drained in order at 1/cycle;
  - assert reset_n=0 mid-drain → out_valid=0 immediately, FIFO empty after release.
